// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from an upstream FIFO with a fixed read
// latency and presents them as a valid/ready stream. A small skid buffer of
// READ_LATENCY+2 entries absorbs the in-flight reads, so the read strobe never
// depends combinationally on the downstream ready.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module fifo_stream_reader #(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic                                   fifo_empty,
  output logic                                   fifo_read_enable,
  input  logic [WIDTH-1:0]                       fifo_read_data,
  output logic                                   stream_valid,
  input  logic                                   stream_ready,
  output logic [WIDTH-1:0]                       stream_data,
  output logic [`CLOG2(READ_LATENCY+3)-1:0]      level
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int PTR_W = `CLOG2(DEPTH);
  localparam int LVL_W = `CLOG2(READ_LATENCY + 3);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (READ_LATENCY < 0 || READ_LATENCY > 2) begin : g_bad_latency
    $error("fifo_stream_reader: READ_LATENCY must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;      // entries held in the buffer
  logic [LVL_W-1:0] level_q, level_d;  // buffered plus reads in flight
  logic             capture, xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // level counts every outstanding read, so it alone guarantees a free slot
  // for each capture; resetn gating keeps the strobe low throughout reset.
  assign fifo_read_enable = resetn && !fifo_empty && (level_q < DEPTH_L);
  assign stream_valid     = (cnt_q != '0);
  assign stream_data      = buf_q[head_q];
  assign xfer             = stream_valid && stream_ready;
  assign level            = level_q;

  if (READ_LATENCY == 0) begin : g_lat0
    assign capture = fifo_read_enable;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] vld_pipe_q;
    // In-flight valid shift register; the last stage marks data arriving now.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        vld_pipe_q <= '0;
      end else begin
        vld_pipe_q[0] <= fifo_read_enable;
        for (int i = 1; i < READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
    assign capture = vld_pipe_q[READ_LATENCY-1];
  end

  // Next-state for pointers and counters; capture and pop may coincide.
  always_comb begin
    tail_d  = capture ? ptr_inc(tail_q) : tail_q;
    head_d  = xfer    ? ptr_inc(head_q) : head_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case ({capture, xfer})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unique case ({fifo_read_enable, xfer})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state; reset discards buffered and in-flight words at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Data storage needs no reset: an entry is only read once cnt_q covers it.
  always_ff @(posedge clock) begin
    if (capture) buf_q[tail_q] <= fifo_read_data;
  end

endmodule
